// File: rtl/ram_sdp_be_init.sv
// Simple dual-port RAM with byte-lane write enables, selectable read-during-write, and a
// self-clearing init sequencer after reset. Define RAM_SDP_OUT_REG_EN for a 2-cycle registered read path.
module ram_sdp_be_init #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_cs,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_cs,
    input  logic                             rd_en,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_valid,
    output logic                             init_busy
);

    localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    ready;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_old;
    logic [DATA_WIDTH-1:0]   rd_merged;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_busy <= 1'b1;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
            if (init_cnt == LAST_ADDR) begin
                state     <= ST_READY;
                init_busy <= 1'b0;
            end
        end
    end

    assign ready       = (state == ST_READY);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_fire     = ready && wr_cs && wr_en && wr_in_range;
    assign rd_fire     = ready && rd_cs && rd_en;

    // Out-of-range reads still strobe rd_valid but return zero.
    always_comb begin
        rd_old    = rd_in_range ? mem[rd_addr] : '0;
        rd_merged = rd_old;
        for (int i = 0; i < NUM_BE; i++) begin
            if (wr_be[i]) begin
                rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_word = (RDW_MODE == 1 && wr_fire && wr_addr == rd_addr) ? rd_merged : rd_old;
    end

    // The array itself has no reset; INIT clears one word per cycle instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_BE; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

`ifdef RAM_SDP_OUT_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_p;
    logic                  rd_valid_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p  <= '0;
            rd_valid_p <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid_p <= rd_fire;
            if (rd_fire) begin
                rd_data_p <= rd_word;
            end
            rd_valid <= rd_valid_p;
            rd_data  <= rd_data_p;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_word;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_sdp_be_init.sv
// Directed bench for ram_sdp_be_init: three instances (old-data, new-data, short-depth)
// share one stimulus stream; expected values are hand-computed constants.
module tb_ram_sdp_be_init;

`ifdef RAM_SDP_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_cs, wr_en, rd_cs, rd_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    logic [31:0] rd_data0, rd_data1, rd_data2;
    logic        rd_valid0, rd_valid1, rd_valid2;
    logic        init_busy0, init_busy1, init_busy2;

    int n_chk;
    int n_pass;

    always #5 clk = ~clk;

    ram_sdp_be_init #(.RDW_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0)
    );

    ram_sdp_be_init #(.RDW_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
    );

    ram_sdp_be_init #(.RAM_DEPTH(200), .RDW_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(init_busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_cs = 1'b1; wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        idle();
    endtask

    task automatic rd(input string tag, input logic [7:0] a,
                      input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
        rd_cs = 1'b1; rd_en = 1'b1; rd_addr = a;
        step();
        idle();
        repeat (LAT - 1) step();
        chk({tag, "_v0"}, 32'(rd_valid0), 32'd1);
        chk({tag, "_v2"}, 32'(rd_valid2), 32'd1);
        chk({tag, "_d0"}, rd_data0, e0);
        chk({tag, "_d1"}, rd_data1, e1);
        chk({tag, "_d2"}, rd_data2, e2);
    endtask

    // Counts edges until dut0 leaves INIT; optionally pokes write/read for the first 150 cycles.
    task automatic init_phase(input string tag, input bit poke);
        int cyc  = 0;
        int cyc2 = 0;
        bit seen = 1'b0;
        bit nz   = 1'b0;
        if (poke) begin
            wr_cs = 1'b1; wr_en = 1'b1; wr_addr = 8'h05; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
            rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 8'h05;
        end
        while (init_busy0 && cyc < 400) begin
            step();
            cyc++;
            if (cyc == 150) idle();
            if (!init_busy2 && cyc2 == 0) cyc2 = cyc;
            if (rd_valid0 || rd_valid1 || rd_valid2) seen = 1'b1;
            if (rd_data0 != 32'd0 || rd_data1 != 32'd0) nz = 1'b1;
        end
        idle();
        chk({tag, "_len256"}, 32'(cyc), 32'd256);
        chk({tag, "_len200"}, 32'(cyc2), 32'd200);
        chk({tag, "_no_valid"}, 32'(seen), 32'd0);
        chk({tag, "_data_zero"}, 32'(nz), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", rd_data0, 32'd0);
        chk("rst_valid", 32'(rd_valid0), 32'd0);
        chk("rst_busy", 32'(init_busy0), 32'd1);
        rst_n = 1'b1;

        init_phase("init", 1'b1);

        rd("rd00", 8'h00, 32'd0, 32'd0, 32'd0);
        rd("rd7f", 8'h7F, 32'd0, 32'd0, 32'd0);
        rd("rdff", 8'hFF, 32'd0, 32'd0, 32'd0);
        rd("rd05", 8'h05, 32'd0, 32'd0, 32'd0);
        step();
        chk("strobe_off", 32'(rd_valid0), 32'd0);

        wr(8'h10, 32'h11223344, 4'b1111);
        wr(8'h10, 32'hAABBCCDD, 4'b0101);
        rd("merge", 8'h10, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        step();
        chk("hold_data", rd_data0, 32'h11BB33DD);

        wr(8'h10, 32'hFFFFFFFF, 4'b0000);
        rd("be_zero", 8'h10, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

        // Same-address read and write on one edge.
        wr_cs = 1'b1; wr_en = 1'b1; wr_addr = 8'h20; wr_data = 32'hCAFEF00D; wr_be = 4'b1100;
        rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 8'h20;
        step();
        idle();
        repeat (LAT - 1) step();
        chk("rdw_old", rd_data0, 32'h00000000);
        chk("rdw_new", rd_data1, 32'hCAFE0000);
        chk("rdw_new2", rd_data2, 32'hCAFE0000);
        rd("rdw_after", 8'h20, 32'hCAFE0000, 32'hCAFE0000, 32'hCAFE0000);

        wr(8'hF0, 32'h12345678, 4'b1111);
        rd("oor", 8'hF0, 32'h12345678, 32'h12345678, 32'h00000000);

        for (int i = 1; i <= 8; i++) wr(8'(i), 32'(i), 4'b1111);
        for (int c = 0; c < 8 + LAT - 1; c++) begin
            if (c < 8) begin
                rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 8'(c + 1);
            end else begin
                idle();
            end
            step();
            if (c >= LAT - 1) begin
                chk("stream_v", 32'(rd_valid0), 32'd1);
                chk("stream_d", rd_data0, 32'(c - LAT + 2));
            end
        end
        idle();
        step();

        for (int c = 0; c < 3; c++) begin
            rd_cs = 1'b1; rd_en = 1'b1; rd_addr = 8'(c + 1);
            step();
        end
        chk("pre_rst_v", 32'(rd_valid0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_v", 32'(rd_valid0), 32'd0);
        chk("arst_d", rd_data0, 32'd0);
        chk("arst_busy", 32'(init_busy0), 32'd1);
        chk("arst_v1", 32'(rd_valid1), 32'd0);
        idle();
        rst_n = 1'b1;

        init_phase("reinit", 1'b0);
        rd("clr10", 8'h10, 32'd0, 32'd0, 32'd0);
        rd("clr01", 8'h01, 32'd0, 32'd0, 32'd0);
        rd("clr20", 8'h20, 32'd0, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
